// File: rtl/cpu_pkg.sv
// Shared types for the multi-cycle sequencer: state encoding, the one-hot
// instruction class and the writeback-class helper.
package cpu_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_FETCH     = 3'd1;
  localparam state_t ST_DECODE    = 3'd2;
  localparam state_t ST_EXECUTE   = 3'd3;
  localparam state_t ST_MEM       = 3'd4;
  localparam state_t ST_WRITEBACK = 3'd5;
  localparam state_t ST_TRAP      = 3'd6;

  // One bit per decoder class flag; exactly one is set for a legal instruction.
  typedef struct packed {
    logic r;
    logic i;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic lui;
    logic auipc;
  } instr_class_t;

  // Classes that write a result back to the register file.
  function automatic logic is_write_class(instr_class_t c);
    return c.r | c.i | c.load | c.jal | c.jalr | c.lui | c.auipc;
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control/handshake bundle between the sequencer, the decoder and the
// shared memory port.
interface cpu_sequencer_if;
  logic r_en, i_en, im_en, s_en, b_en, jal_en, jalr_en, lui_en, auipc_en;
  logic branch;
  logic mem_ready;
  logic mem_req, mem_fetch, mem_we;
  logic ir_load, pc_write, pc_sel, reg_write;
  logic illegal;

  modport master (
    input  r_en, i_en, im_en, s_en, b_en, jal_en, jalr_en, lui_en, auipc_en,
    input  branch, mem_ready,
    output mem_req, mem_fetch, mem_we, ir_load, pc_write, pc_sel, reg_write,
    output illegal
  );

  modport slave (
    output r_en, i_en, im_en, s_en, b_en, jal_en, jalr_en, lui_en, auipc_en,
    output branch, mem_ready,
    input  mem_req, mem_fetch, mem_we, ir_load, pc_write, pc_sel, reg_write,
    input  illegal
  );
endinterface

// File: rtl/perf_counter.sv
// Free-running event counter with enable; wraps silently at 2^W.
module perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] cnt
);

  // Count enabled cycles, natural modulo-2^W wrap.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (reset) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM: fetch, decode, execute, memory, writeback over a
// single shared memory port, plus cycle and retired-instruction counters.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  cpu_sequencer_if.master  bus,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  state_t       state;
  instr_class_t cls;
  instr_class_t flags;
  logic         branch_taken;
  logic         illegal_q;

  assign flags = {bus.r_en, bus.i_en, bus.im_en, bus.s_en, bus.b_en,
                  bus.jal_en, bus.jalr_en, bus.lui_en, bus.auipc_en};

  // State transitions plus the decode-time class latch and sticky illegal flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      cls          <= '0;
      branch_taken <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:  state <= ST_FETCH;
        ST_FETCH: if (bus.mem_ready) state <= ST_DECODE;
        ST_DECODE: begin
          cls <= flags;
          if ($countones(flags) != 1) begin
            illegal_q <= 1'b1;
            state     <= ST_TRAP;
          end else begin
            state <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          // Live flags are stale here; the latched class stands in for b_en.
          branch_taken <= cls.branch & bus.branch;
          state        <= (cls.load | cls.store) ? ST_MEM : ST_WRITEBACK;
        end
        ST_MEM:       if (bus.mem_ready) state <= ST_WRITEBACK;
        ST_WRITEBACK: state <= ST_FETCH;
        ST_TRAP:      state <= ST_TRAP;
        default:      state <= ST_IDLE;
      endcase
    end
  end

  // Output strobes decoded from state and latched class; ir_load is the only
  // term that also looks at mem_ready.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one
    // unassigned and infers a latch.
    bus.mem_req   = 1'b0;
    bus.mem_fetch = 1'b0;
    bus.mem_we    = 1'b0;
    bus.ir_load   = 1'b0;
    bus.pc_write  = 1'b0;
    bus.pc_sel    = 1'b0;
    bus.reg_write = 1'b0;
    case (state)
      ST_FETCH: begin
        bus.mem_req   = 1'b1;
        bus.mem_fetch = 1'b1;
        bus.ir_load   = bus.mem_ready;
      end
      ST_MEM: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = cls.store;
      end
      ST_WRITEBACK: begin
        bus.pc_write  = 1'b1;
        bus.pc_sel    = cls.jal | cls.jalr | branch_taken;
        bus.reg_write = is_write_class(cls);
      end
      default: ;
    endcase
  end

  assign bus.illegal = illegal_q;

  perf_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .en    ((state != ST_IDLE) && (state != ST_TRAP)),
    .cnt   (cycle_cnt)
  );

  perf_counter #(.W(CNT_W)) u_instret_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (state == ST_WRITEBACK),
    .cnt   (instret_cnt)
  );

endmodule
